serial_parity_checker: RTL and testbench

Receiving end of the lab's serial parity link: accepts a framed serial bit stream (start strobe, DATA_BITS data bits LSB-first, one parity bit) and reassembles the data word. It checks the running XOR of data and parity against the configured parity sense. It reports a per-frame done pulse, an error flag, and a saturating error count. It sits between the serial line front end and the display/LED logic of the board-level designs.

---
 rtl/serial_parity_checker_pkg.sv | 14 +
 rtl/serial_parity_checker_parity_accum.sv | 26 ++
 rtl/serial_parity_checker.sv | 124 ++++++++++++
 tb/tb_serial_parity_checker.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_parity_checker_pkg.sv
// Shared types and constants for the serial parity receiver.
// State encoding and error-counter limits live here.
package serial_parity_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2
  } state_e;

  localparam int ERR_CNT_W = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

endpackage

// File: rtl/serial_parity_checker_parity_accum.sv
// Running XOR of the serial bits of the current frame.
// A clear with en set seeds the register with that bit.
module serial_parity_checker_parity_accum (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  input  logic bit_in,
  output logic parity_o
);

  logic par_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else if (clear) begin
      par_q <= en & bit_in;
    end else if (en) begin
      par_q <= par_q ^ bit_in;
    end
  end

  assign parity_o = par_q;

endmodule

// File: rtl/serial_parity_checker.sv
// Serial frame receiver: start, DATA_BITS LSB-first, parity.
// Reports word, parity result, done pulse, error count.
module serial_parity_checker
  import serial_parity_checker_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int ODD_PARITY = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 frame_done,
  output logic                 parity_err,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_BITS - 1);
  localparam logic ODD = (ODD_PARITY != 0);

  state_e state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic done_q, done_d;
  logic err_q, err_d;
  logic [ERR_CNT_W-1:0] ecnt_q, ecnt_d;
  logic acc_clr, acc_en, acc_par;
  logic mismatch;

  serial_parity_checker_parity_accum u_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (acc_clr),
    .en       (acc_en),
    .bit_in   (bit_in),
    .parity_o (acc_par)
  );

  assign mismatch = acc_par ^ bit_in ^ ODD;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = err_q;
    ecnt_d  = ecnt_q;
    acc_clr = 1'b0;
    acc_en  = 1'b0;
    if (start) begin
      acc_clr = 1'b1;
      acc_en  = bit_valid;
      state_d = ST_DATA;
      if (bit_valid) begin
        // bits enter at the MSB and walk down to their final slot
        shift_d = {bit_in, {(DATA_BITS-1){1'b0}}};
        cnt_d   = CW'(1);
      end else begin
        shift_d = '0;
        cnt_d   = '0;
      end
    end else begin
      case (state_q)
        ST_DATA: begin
          if (bit_valid) begin
            acc_en  = 1'b1;
            shift_d = {bit_in, shift_q[DATA_BITS-1:1]};
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
              state_d = ST_PARITY;
            end
          end
        end
        ST_PARITY: begin
          if (bit_valid) begin
            data_d  = shift_q;
            err_d   = mismatch;
            done_d  = 1'b1;
            state_d = ST_IDLE;
            if (mismatch && ecnt_q != ERR_CNT_MAX) begin
              ecnt_d = ecnt_q + 8'd1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ecnt_q  <= ecnt_d;
    end
  end

  assign data_out   = data_q;
  assign frame_done = done_q;
  assign parity_err = err_q;
  assign err_count  = ecnt_q;
  assign busy       = (state_q == ST_DATA) || (state_q == ST_PARITY);

endmodule

// File: tb/tb_serial_parity_checker.sv
// Bench for serial_parity_checker: even and odd instances
// against a frame-level queue model plus literal checks.
module tb_serial_parity_checker;

  localparam int DB = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic start, bit_in, bit_valid;

  logic [DB-1:0] dout_e, dout_o;
  logic done_e, done_o, perr_e, perr_o, busy_e, busy_o;
  logic [7:0] ecnt_e, ecnt_o;

  int n_vec = 0;
  int n_bad = 0;
  int ndone_e = 0;
  int ndone_o = 0;

  always #5 clk = ~clk;

  serial_parity_checker #(.DATA_BITS(DB), .ODD_PARITY(0)) u_even (
    .clk(clk), .rst_n(rst_n), .start(start), .bit_in(bit_in),
    .bit_valid(bit_valid), .data_out(dout_e), .frame_done(done_e),
    .parity_err(perr_e), .busy(busy_e), .err_count(ecnt_e)
  );

  serial_parity_checker #(.DATA_BITS(DB), .ODD_PARITY(1)) u_odd (
    .clk(clk), .rst_n(rst_n), .start(start), .bit_in(bit_in),
    .bit_valid(bit_valid), .data_out(dout_o), .frame_done(done_o),
    .parity_err(perr_o), .busy(busy_o), .err_count(ecnt_o)
  );

  // frame-level model: collect bits, judge once DB+1 are in
  logic       m_active;
  bit         m_q[$];
  logic [DB-1:0] m_data;
  logic       m_done, m_err_e, m_err_o;
  int         m_cnt_e, m_cnt_o;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_q.delete();
      m_data = '0;
      m_done = 1'b0;
      m_err_e = 1'b0;
      m_err_o = 1'b0;
      m_cnt_e = 0;
      m_cnt_o = 0;
    end else begin
      m_done = 1'b0;
      if (start) begin
        m_q.delete();
        m_active = 1'b1;
        if (bit_valid) m_q.push_back(bit_in);
      end else if (m_active && bit_valid) begin
        m_q.push_back(bit_in);
        if (m_q.size() == DB + 1) begin
          automatic int ones = 0;
          for (int i = 0; i < DB + 1; i++) ones += int'(m_q[i]);
          for (int i = 0; i < DB; i++) m_data[i] = m_q[i];
          m_err_e = (ones % 2) != 0;
          m_err_o = (ones % 2) == 0;
          if (m_err_e && m_cnt_e < 255) m_cnt_e++;
          if (m_err_o && m_cnt_o < 255) m_cnt_o++;
          m_done = 1'b1;
          m_active = 1'b0;
          m_q.delete();
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("data_e", int'(dout_e), int'(m_data));
      chk("data_o", int'(dout_o), int'(m_data));
      chk("done_e", int'(done_e), int'(m_done));
      chk("done_o", int'(done_o), int'(m_done));
      chk("perr_e", int'(perr_e), int'(m_err_e));
      chk("perr_o", int'(perr_o), int'(m_err_o));
      chk("busy_e", int'(busy_e), int'(m_active));
      chk("busy_o", int'(busy_o), int'(m_active));
      chk("ecnt_e", int'(ecnt_e), m_cnt_e);
      chk("ecnt_o", int'(ecnt_o), m_cnt_o);
      ndone_e += int'(done_e);
      ndone_o += int'(done_o);
    end
  end

  task automatic drive(input logic s, input logic v, input logic b);
    @(negedge clk);
    start = s;
    bit_valid = v;
    bit_in = b;
  endtask

  task automatic gap(input int maxgap);
    if (maxgap > 0) begin
      repeat ($urandom_range(1, maxgap)) drive(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic send_bits(input logic [DB-1:0] w, input int from,
                           input int maxgap);
    for (int i = from; i < DB; i++) begin
      gap(maxgap);
      drive(1'b0, 1'b1, w[i]);
    end
  endtask

  task automatic send_frame(input logic [DB-1:0] w, input logic p,
                            input int maxgap);
    drive(1'b1, 1'b0, 1'b0);
    send_bits(w, 0, maxgap);
    gap(maxgap);
    drive(1'b0, 1'b1, p);
    drive(1'b0, 1'b0, 1'b0);
  endtask

  int d0;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    bit_valid = 1'b0;
    bit_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy_e), 0);
    chk("rst_data", int'(dout_e), 0);
    chk("rst_ecnt", int'(ecnt_e), 0);
    chk("rst_done", int'(done_e), 0);
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0);

    send_frame(8'hA5, 1'b0, 0);
    chk("a5_done", int'(done_e), 1);
    chk("a5_data", int'(dout_e), 8'hA5);
    chk("a5_perr", int'(perr_e), 0);
    chk("a5_ecnt", int'(ecnt_e), 0);
    drive(1'b0, 1'b0, 1'b0);
    chk("a5_pulse", int'(done_e), 0);
    chk("a5_hold", int'(dout_e), 8'hA5);

    send_frame(8'hA5, 1'b1, 0);
    chk("bad_perr", int'(perr_e), 1);
    chk("bad_ecnt", int'(ecnt_e), 1);
    send_frame(8'h3C, 1'b0, 0);
    chk("3c_perr", int'(perr_e), 0);
    chk("3c_data", int'(dout_e), 8'h3C);
    chk("3c_ecnt", int'(ecnt_e), 1);

    send_frame(8'h01, 1'b0, 0);
    chk("odd01_perr", int'(perr_o), 0);
    chk("even01_perr", int'(perr_e), 1);
    send_frame(8'h03, 1'b0, 0);
    chk("odd03_perr", int'(perr_o), 1);

    d0 = ndone_e;
    drive(1'b1, 1'b0, 1'b0);
    send_bits(8'hF0, 4, 5);
    chk("partial_busy", int'(busy_e), 1);
    drive(1'b1, 1'b0, 1'b0);
    send_bits(8'hF0, 0, 5);
    gap(5);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    chk("gap_ndone", ndone_e - d0, 1);
    chk("f0_data", int'(dout_e), 8'hF0);
    chk("f0_perr", int'(perr_e), 0);

    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    bit_valid = 1'b0;
    #1;
    chk("arst_busy", int'(busy_e), 0);
    chk("arst_data", int'(dout_e), 0);
    chk("arst_ecnt", int'(ecnt_e), 0);
    chk("arst_done", int'(done_e), 0);
    #1 rst_n = 1'b1;
    d0 = ndone_e;
    repeat (12) drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    chk("arst_nodone", ndone_e - d0, 0);

    d0 = ndone_e;
    for (int f = 0; f < 260; f++) begin
      drive(1'b1, 1'b1, 1'b0);
      for (int i = 1; i < DB; i++) drive(1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b1);
    end
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    chk("sat_ecnt", int'(ecnt_e), 255);
    chk("sat_ndone", ndone_e - d0, 260);
    chk("sat_odd_ecnt", int'(ecnt_o), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
